// File: rtl/alu_input_encoder.sv
// Operand/opcode entry front end: debounces BTNC/BTNL and steps A -> B -> OpCode.
// Ports: CLK100MHZ, reset, SW, BTNC, BTNL in; A, B, OpCode, DispCont, stage, go out.

module alu_btn_cond #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          db;
  logic          db_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db   <= 1'b0;
      db_q <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      db_q <= db;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Rising edge of the accepted level only; releases are silent.
  assign press = db & ~db_q;

endmodule

module alu_input_encoder #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic       CLK100MHZ,
  input  logic       reset,
  input  logic [3:0] SW,
  input  logic       BTNC,
  input  logic       BTNL,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [3:0] OpCode,
  output logic       DispCont,
  output logic [1:0] stage,
  output logic       go
);

  typedef enum logic [1:0] {
    S_A   = 2'd0,
    S_B   = 2'd1,
    S_OP  = 2'd2,
    S_RUN = 2'd3
  } state_t;

  state_t state;
  logic   press_c;
  logic   press_l;
  logic   commit;
  logic   back;

  alu_btn_cond #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_c (
    .clk  (CLK100MHZ),
    .rst  (reset),
    .raw  (BTNC),
    .press(press_c)
  );

  alu_btn_cond #(
    .DB_CYCLES(DB_CYCLES)
  ) u_btn_l (
    .clk  (CLK100MHZ),
    .rst  (reset),
    .raw  (BTNL),
    .press(press_l)
  );

  // Coincident presses are ambiguous, so both are dropped.
  assign commit = press_c & ~press_l;
  assign back   = press_l & ~press_c;
  assign stage  = state;

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      state    <= S_A;
      A        <= '0;
      B        <= '0;
      OpCode   <= '0;
      DispCont <= 1'b0;
      go       <= 1'b0;
    end else begin
      go <= 1'b0;
      unique case (1'b1)
        commit: begin
          case (state)
            S_A: begin
              A     <= SW;
              state <= S_B;
            end
            S_B: begin
              B     <= SW;
              state <= S_OP;
            end
            S_OP: begin
              OpCode   <= SW;
              DispCont <= 1'b1;
              go       <= 1'b1;
              state    <= S_RUN;
            end
            S_RUN: begin
              DispCont <= 1'b0;
              state    <= S_A;
            end
            default: state <= S_A;
          endcase
        end
        back: begin
          case (state)
            S_A:  state <= S_A;
            S_B:  state <= S_A;
            S_OP: state <= S_B;
            S_RUN: begin
              DispCont <= 1'b0;
              state    <= S_OP;
            end
            default: state <= S_A;
          endcase
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_input_encoder.sv
// Bench for alu_input_encoder with DB_CYCLES=4.
// Window-based debounce model plus directed literal checks.

module tb_alu_input_encoder;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] SW = 4'h0;
  logic       BTNC = 1'b0;
  logic       BTNL = 1'b0;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] OpCode;
  logic       DispCont;
  logic [1:0] stage;
  logic       go;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_input_encoder #(
    .DB_CYCLES(DB)
  ) dut (
    .CLK100MHZ(clk),
    .reset    (reset),
    .SW       (SW),
    .BTNC     (BTNC),
    .BTNL     (BTNL),
    .A        (A),
    .B        (B),
    .OpCode   (OpCode),
    .DispCont (DispCont),
    .stage    (stage),
    .go       (go)
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a level is accepted once DB consecutive synchronized
  // samples (raw taken two edges earlier) disagree with it.
  logic [3:0] m_a, m_b, m_op;
  logic       m_disp, m_go;
  int         m_st;
  bit         qc[$];
  bit         ql[$];
  bit         dbc, dbl, pc, pl;

  function automatic bit settled(input bit q[$], input bit lvl);
    for (int i = 0; i < DB; i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_a = 0; m_b = 0; m_op = 0;
      m_disp = 0; m_go = 0; m_st = 0;
      dbc = 0; dbl = 0; pc = 0; pl = 0;
      qc = {}; ql = {};
      repeat (DB + 1) begin
        qc.push_back(1'b0);
        ql.push_back(1'b0);
      end
    end else begin
      bit fc, fl;
      m_go = 0;
      if (pc && !pl) begin
        case (m_st)
          0: begin m_a = SW; m_st = 1; end
          1: begin m_b = SW; m_st = 2; end
          2: begin m_op = SW; m_disp = 1; m_go = 1; m_st = 3; end
          default: begin m_disp = 0; m_st = 0; end
        endcase
      end else if (pl && !pc) begin
        case (m_st)
          1: m_st = 0;
          2: m_st = 1;
          3: begin m_st = 2; m_disp = 0; end
          default: m_st = 0;
        endcase
      end
      fc = settled(qc, dbc);
      fl = settled(ql, dbl);
      pc = fc && !dbc;
      pl = fl && !dbl;
      if (fc) dbc = ~dbc;
      if (fl) dbl = ~dbl;
      qc.push_back(BTNC); void'(qc.pop_front());
      ql.push_back(BTNL); void'(ql.pop_front());
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        chk("m_A", A, m_a);
        chk("m_B", B, m_b);
        chk("m_OpCode", OpCode, m_op);
        chk("m_DispCont", DispCont, m_disp);
        chk("m_stage", stage, m_st);
        chk("m_go", go, m_go);
      end
    end
  end

  task automatic hit(input bit c, input bit l, input logic [3:0] sw,
                     output int gos, output int boths);
    gos = 0;
    boths = 0;
    @(negedge clk);
    SW = sw;
    BTNC = c;
    BTNL = l;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) begin
        @(negedge clk);
        BTNC = 1'b0;
        BTNL = 1'b0;
      end
      @(posedge clk);
      #1;
      if (go) gos++;
      if (dut.press_c && dut.press_l) boths++;
    end
  endtask

  initial begin
    int g, b, maxc;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_OpCode", OpCode, 0);
    chk("rst_DispCont", DispCont, 0);
    chk("rst_stage", stage, 0);
    chk("rst_go", go, 0);

    // held commit: one update at edge 7
    @(negedge clk);
    SW = 4'hA;
    BTNC = 1'b1;
    g = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (go) g++;
      if (i == 6) chk("hold_e6_stage", stage, 0);
      if (i == 7) begin
        chk("hold_e7_A", A, 4'hA);
        chk("hold_e7_stage", stage, 1);
        chk("hold_e7_B", B, 0);
      end
    end
    chk("hold_e20_stage", stage, 1);
    chk("hold_OpCode", OpCode, 0);
    chk("hold_DispCont", DispCont, 0);
    chk("hold_go_count", g, 0);
    @(negedge clk);
    BTNC = 1'b0;
    repeat (10) @(negedge clk);

    // full entry
    hit(1, 0, 4'h3, g, b);
    chk("entry_B", B, 4'h3);
    chk("entry_stage_op", stage, 2);
    hit(1, 0, 4'h0, g, b);
    chk("entry_go_count", g, 1);
    chk("entry_A", A, 4'hA);
    chk("entry_OpCode", OpCode, 0);
    chk("entry_stage_run", stage, 3);
    chk("entry_DispCont", DispCont, 1);
    hit(1, 0, 4'hC, g, b);
    chk("rerun_stage", stage, 0);
    chk("rerun_DispCont", DispCont, 0);
    chk("rerun_A", A, 4'hA);
    chk("rerun_B", B, 4'h3);

    // bounce
    maxc = 0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      BTNC = (i < 12) && ((i / 2) % 2 == 0);
      @(posedge clk);
      #1;
      if (int'(dut.u_btn_c.cnt) > maxc) maxc = int'(dut.u_btn_c.cnt);
    end
    chk("bounce_stage", stage, 0);
    chk("bounce_cnt_max", maxc, 2);

    // back
    hit(1, 0, 4'h5, g, b);
    hit(1, 0, 4'h6, g, b);
    chk("back_pre_stage", stage, 2);
    hit(0, 1, 4'hF, g, b);
    chk("back_op_stage", stage, 1);
    chk("back_op_A", A, 4'h5);
    chk("back_op_B", B, 4'h6);
    hit(0, 1, 4'hF, g, b);
    chk("back_b_stage", stage, 0);
    hit(0, 1, 4'hF, g, b);
    chk("back_a_stage", stage, 0);
    chk("back_a_A", A, 4'h5);
    hit(1, 0, 4'h1, g, b);
    hit(1, 0, 4'h2, g, b);
    hit(1, 0, 4'h7, g, b);
    chk("back_run_go", g, 1);
    chk("back_run_disp", DispCont, 1);
    hit(0, 1, 4'hF, g, b);
    chk("back_run_stage", stage, 2);
    chk("back_run_disp0", DispCont, 0);
    chk("back_run_op", OpCode, 4'h7);

    // simultaneous in S_B
    hit(1, 0, 4'h8, g, b);
    chk("sim_pre_op", OpCode, 4'h8);
    hit(1, 0, 4'h0, g, b);
    hit(1, 0, 4'h9, g, b);
    chk("sim_pre_stage", stage, 1);
    hit(1, 1, 4'hF, g, b);
    chk("sim_both_cycles", b, 1);
    chk("sim_stage", stage, 1);
    chk("sim_B", B, 4'h2);

    // async reset in S_RUN
    hit(1, 0, 4'h4, g, b);
    hit(1, 0, 4'h8, g, b);
    chk("ar_pre_disp", DispCont, 1);
    chk("ar_pre_stage", stage, 3);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_A", A, 0);
    chk("ar_B", B, 0);
    chk("ar_OpCode", OpCode, 0);
    chk("ar_DispCont", DispCont, 0);
    chk("ar_stage", stage, 0);
    chk("ar_go", go, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_idle_stage", stage, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_input_encoder.md
Name: alu_input_encoder

Overview:
- Operand/opcode entry front end for the ALU display path.
- Debounces board pushbuttons, then steps through entering A, B and OpCode from the slide switches.
- Drives the A/B/OpCode/DispCont inputs consumed by the ALU decoder and seven-segment stage.
- Emits a one-cycle go strobe when a complete operation has been entered.

Parameters:
- DB_CYCLES, 1000000, consecutive stable clocks required to accept a button level change (10 ms at 100 MHz). Benches use 4. Legal range is 2 or more.

Ports:
- CLK100MHZ  input  1  system clock, 100 MHz
- reset  input  1  asynchronous, active-high reset
- SW  input  4  nibble value captured on commit
- BTNC  input  1  raw commit pushbutton, asynchronous to the clock, bouncy
- BTNL  input  1  raw back pushbutton, asynchronous to the clock, bouncy
- A  output  4  registered operand A
- B  output  4  registered operand B
- OpCode  output  4  registered opcode
- DispCont  output  1  high while a completed operation is being displayed
- stage  output  2  current entry state: 0=S_A, 1=S_B, 2=S_OP, 3=S_RUN
- go  output  1  one-cycle strobe on entering S_RUN

Behaviour:
- Interface (decided): one clock, CLK100MHZ. reset is asynchronous and active-high, and every flop clears immediately on assertion.
- Reset values:
  - A=0, B=0, OpCode=0, DispCont=0, stage=0 (S_A), go=0.
  - Synchronizers, debounced levels and counters are cleared to 0.
- Button conditioning (per button, independent):
  - Two-flop synchronizer s1 -> s2.
  - Counter cnt: clears whenever s2 == db. Increments while s2 != db.
  - When cnt == DB_CYCLES-1 and s2 != db: db <= s2 and cnt <= 0.
  - db_q is db registered one cycle later.
  - press = db & ~db_q, combinational, high for exactly one cycle per accepted rising level. Releases produce no pulse.
  - A glitch shorter than DB_CYCLES clocks resets cnt and never changes db.
- Latency: raw button rises before edge 1 and stays high. db rises at edge DB_CYCLES+2, press is high during the following cycle, and the FSM/register update lands on edge DB_CYCLES+3.
- FSM, actions on pressC (commit):
  - S_A: A<=SW, go to S_B.
  - S_B: B<=SW, go to S_OP.
  - S_OP: OpCode<=SW, DispCont<=1, go<=1 for one cycle, go to S_RUN.
  - S_RUN: DispCont<=0, go to S_A. A, B and OpCode are retained until overwritten.
- FSM, actions on pressL (back):
  - S_B -> S_A.
  - S_OP -> S_B.
  - S_RUN -> S_OP with DispCont<=0.
  - S_A: ignored.
  - Back never modifies A, B or OpCode.
- pressC and pressL in the same cycle: both ignored, and state and registers are unchanged.
- SW is sampled unsynchronized at the commit edge. The user is expected to hold the switches static; no SW filtering is performed.
- go is registered. It is high only in the first cycle of S_RUN and never high outside S_RUN.
- Holding a button produces exactly one press. A second action requires a debounced release followed by a new debounced press.
- Reset mid-debounce or mid-entry returns to S_A with all outputs at their reset values. A button held through reset release yields one press after DB_CYCLES+3 edges, because db restarts at 0.
- stage always equals the encoded current state.

Test Plan (DB_CYCLES=4, 10 ns clock):
- Reset, then hold BTNC high for 20 cycles with SW=4'hA -> exactly one update at edge 7: A=4'hA, stage=1, B/OpCode/DispCont/go stay 0.
- Full entry: commit SW=A, 3, 0 in turn, releasing between commits -> A=4'hA, B=4'h3, OpCode=4'h0, stage=3, DispCont=1, go high exactly one cycle. A further commit -> stage=0, DispCont=0, values retained.
- Bounce: BTNC toggles every 2 cycles for 12 cycles, then stays low -> no press, stage unchanged, cnt never reaches 3.
- Back: in S_OP press BTNL -> stage=1, registers unchanged. In S_A press BTNL -> stage=0, no change. In S_RUN press BTNL -> stage=2, DispCont=0.
- Simultaneous: BTNC and BTNL rise on the same edge in S_B -> both press on the same cycle, stage stays 1, B unchanged.
- Async reset asserted mid-cycle while in S_RUN with DispCont=1 -> all outputs are 0 before the next clock edge. After release with no buttons pressed, stage stays 0.
